operand_fetch_seq: RTL and testbench

Sequences the single synchronous read port of the register file to gather up to three source operands (Rn, Rm, Rs) per instruction and deliver them to the operand-select muxes. Reads of R15 are replaced by PC + PC_OFFSET and never touch the register file. Sits between decode and the src1/X/Y operand muxes. Valid/ready handshake on both sides.

---
 rtl/operand_fetch_seq.sv | 147 ++++++++++++++
 tb/tb_operand_fetch_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: gathers Rn/Rm/Rs through one synchronous RF read port, substituting PC+PC_OFFSET for R15.
// Optional OPFETCH_B2B_EN lets a new request be accepted straight out of DONE.
module operand_fetch_seq #(
  parameter int DW        = 32,
  parameter int AW        = 4,
  parameter int PC_OFFSET = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic [AW-1:0] req_rs,
  input  logic [2:0]    req_need,
  input  logic [DW-1:0] req_pc,
  output logic          rf_ren,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_rdata,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_rn,
  output logic [DW-1:0] op_rm,
  output logic [DW-1:0] op_rs
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  typedef struct packed {
    logic [2:0][AW-1:0] addr;
    logic [DW-1:0]      pc;
  } req_t;

  localparam logic [AW-1:0] PC_REG = AW'(15);
  localparam logic [DW-1:0] PC_INC = DW'(PC_OFFSET);

  state_t             state;
  req_t               cur;
  logic [2:0]         rem;
  logic [2:0][DW-1:0] ops;
  logic               rdy_q;
  logic               pend_vld;
  logic [1:0]         pend_slot;

  function automatic logic [1:0] pick(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  // Issue decision for the accept cycle, taken straight from the request.
  logic [2:0][AW-1:0] req_addr;
  logic [1:0]         acc_sel;
  logic               acc_ren;
  assign req_addr = {req_rs, req_rm, req_rn};
  assign acc_sel  = pick(req_need);
  assign acc_ren  = (req_need != 3'b000) && (req_addr[acc_sel] != PC_REG);

  // Current FETCH issue and the one that follows it; rf_ren/rf_addr are
  // registered, so the following issue is decided one edge early.
  logic [1:0] sel;
  logic [2:0] rem_nxt;
  logic [1:0] nxt_sel;
  logic       nxt_ren;
  assign sel     = pick(rem);
  assign rem_nxt = rem & ~(3'b001 << sel);
  assign nxt_sel = pick(rem_nxt);
  assign nxt_ren = (rem_nxt != 3'b000) && (cur.addr[nxt_sel] != PC_REG);

  logic accept;
  logic done_take;
`ifdef OPFETCH_B2B_EN
  assign done_take = (state == DONE) && op_ready && req_valid;
  assign req_ready = rdy_q | ((state == DONE) && op_ready);
`else
  assign done_take = 1'b0;
  assign req_ready = rdy_q;
`endif
  assign accept = ((state == IDLE) && req_valid) || done_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      rem       <= '0;
      ops       <= '0;
      rdy_q     <= 1'b1;
      op_valid  <= 1'b0;
      rf_ren    <= 1'b0;
      rf_addr   <= '0;
      pend_vld  <= 1'b0;
      pend_slot <= '0;
    end else if (accept) begin
      state     <= FETCH;
      cur.addr  <= req_addr;
      cur.pc    <= req_pc;
      rem       <= req_need;
      ops       <= '0;
      rdy_q     <= 1'b0;
      op_valid  <= 1'b0;
      rf_ren    <= acc_ren;
      rf_addr   <= acc_ren ? req_addr[acc_sel] : '0;
      pend_vld  <= 1'b0;
      pend_slot <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
        end
        FETCH: begin
          if (pend_vld) ops[pend_slot] <= rf_rdata;
          if (rem == 3'b000) begin
            state    <= DONE;
            op_valid <= 1'b1;
            rf_ren   <= 1'b0;
            rf_addr  <= '0;
            pend_vld <= 1'b0;
          end else begin
            // pend_slot never equals sel: its mask bit was cleared a cycle ago.
            if (cur.addr[sel] == PC_REG) ops[sel] <= cur.pc + PC_INC;
            pend_vld  <= rf_ren;
            pend_slot <= sel;
            rem       <= rem_nxt;
            rf_ren    <= nxt_ren;
            rf_addr   <= nxt_ren ? cur.addr[nxt_sel] : '0;
          end
        end
        DONE: begin
          if (op_ready) begin
            state    <= IDLE;
            op_valid <= 1'b0;
            rdy_q    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign op_rn = ops[0];
  assign op_rm = ops[1];
  assign op_rs = ops[2];

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Directed bench for operand_fetch_seq; RF model returns 100+addr one cycle after a read.
module tb_operand_fetch_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_rn, req_rm, req_rs;
  logic [2:0]  req_need;
  logic [31:0] req_pc;
  logic        rf_ren;
  logic [3:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        op_valid, op_ready;
  logic [31:0] op_rn, op_rm, op_rs;

  int pass_cnt = 0;
  int total    = 0;

  operand_fetch_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_rs(req_rs),
    .req_need(req_need), .req_pc(req_pc),
    .rf_ren(rf_ren), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rn(op_rn), .op_rm(op_rm), .op_rs(op_rs)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rf_rdata <= rf_ren ? (32'd100 + 32'(rf_addr)) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
                       input logic [2:0] need, input logic [31:0] pc);
    req_valid = 1'b1; req_rn = rn; req_rm = rm; req_rs = rs; req_need = need; req_pc = pc;
  endtask

  task automatic scramble();
    req_valid = 1'b0; req_rn = 4'd9; req_rm = 4'd10; req_rs = 4'd11; req_need = 3'b111; req_pc = 32'd4444;
  endtask

  initial begin
    rst_n = 1'b0; op_ready = 1'b0;
    req_valid = 1'b0; req_rn = '0; req_rm = '0; req_rs = '0; req_need = '0; req_pc = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_op_valid",  32'(op_valid), 0);
    chk("rst_rf_ren",    32'(rf_ren), 0);
    chk("rst_rf_addr",   32'(rf_addr), 0);
    chk("rst_ops",       op_rn | op_rm | op_rs, 0);
    rst_n = 1'b1;
    step();

    // Three register reads
    offer(4'd3, 4'd5, 4'd7, 3'b111, 32'd0);
    chk("t1_accept_ready", 32'(req_ready), 1);
    step(); scramble();                                  // T1
    chk("t1_ren_T1", 32'(rf_ren), 1); chk("t1_addr_T1", 32'(rf_addr), 3);
    chk("t1_busy_ready", 32'(req_ready), 0);
    step();                                              // T2
    chk("t1_ren_T2", 32'(rf_ren), 1); chk("t1_addr_T2", 32'(rf_addr), 5);
    step();                                              // T3
    chk("t1_ren_T3", 32'(rf_ren), 1); chk("t1_addr_T3", 32'(rf_addr), 7);
    step();                                              // T4
    chk("t1_ren_T4", 32'(rf_ren), 0); chk("t1_addr_T4", 32'(rf_addr), 0);
    chk("t1_vld_T4", 32'(op_valid), 0);
    step();                                              // T5
    chk("t1_vld_T5", 32'(op_valid), 1);
    chk("t1_rn", op_rn, 103); chk("t1_rm", op_rm, 105); chk("t1_rs", op_rs, 107);
    op_ready = 1'b1;
    step();
    chk("t1_idle_vld", 32'(op_valid), 0); chk("t1_idle_ready", 32'(req_ready), 1);
    op_ready = 1'b0;

    // R15 only, then hold in DONE
    offer(4'd15, 4'd0, 4'd0, 3'b001, 32'd184);
    step(); scramble();                                  // T1
    chk("t2_ren_T1", 32'(rf_ren), 0);
    step();                                              // T2
    chk("t2_ren_T2", 32'(rf_ren), 0); chk("t2_vld_T2", 32'(op_valid), 0);
    step();                                              // T3
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_vld", 32'(op_valid), 1);
      chk("t2_hold_rn", op_rn, 192); chk("t2_hold_rm", op_rm, 0); chk("t2_hold_rs", op_rs, 0);
      chk("t2_hold_ready", 32'(req_ready), 0); chk("t2_hold_ren", 32'(rf_ren), 0);
      step();
    end
    chk("t2_still_vld", 32'(op_valid), 1);
    op_ready = 1'b1;
    step();
    chk("t2_idle_vld", 32'(op_valid), 0); chk("t2_idle_ready", 32'(req_ready), 1);
    op_ready = 1'b0;

    // Empty mask
    offer(4'd1, 4'd2, 4'd3, 3'b000, 32'd50);
    step(); scramble();                                  // T1
    chk("t3_vld_T1", 32'(op_valid), 0); chk("t3_ren_T1", 32'(rf_ren), 0);
    step();                                              // T2
    chk("t3_vld_T2", 32'(op_valid), 1);
    chk("t3_ops", op_rn | op_rm | op_rs, 0);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;

    // Rn read plus Rs = R15, Rm unused
    offer(4'd2, 4'd9, 4'd15, 3'b101, 32'd0);
    step(); scramble();                                  // T1
    chk("t4_ren_T1", 32'(rf_ren), 1); chk("t4_addr_T1", 32'(rf_addr), 2);
    step();                                              // T2
    chk("t4_ren_T2", 32'(rf_ren), 0); chk("t4_addr_T2", 32'(rf_addr), 0);
    step();                                              // T3
    chk("t4_ren_T3", 32'(rf_ren), 0); chk("t4_vld_T3", 32'(op_valid), 0);
    step();                                              // T4
    chk("t4_vld_T4", 32'(op_valid), 1);
    chk("t4_rn", op_rn, 102); chk("t4_rm", op_rm, 0); chk("t4_rs", op_rs, 8);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;

    // Reset in the middle of FETCH
    offer(4'd4, 4'd6, 4'd1, 3'b111, 32'd0);
    step(); scramble();                                  // T1
    chk("t5_ren_T1", 32'(rf_ren), 1); chk("t5_addr_T1", 32'(rf_addr), 4);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(req_ready), 1); chk("t5_rst_vld", 32'(op_valid), 0);
    chk("t5_rst_ren", 32'(rf_ren), 0); chk("t5_rst_addr", 32'(rf_addr), 0);
    chk("t5_rst_ops", op_rn | op_rm | op_rs, 0);
    step();
    rst_n = 1'b1;
    step();
    offer(4'd8, 4'd0, 4'd0, 3'b001, 32'd0);
    step(); scramble();                                  // T1
    chk("t5_ren2", 32'(rf_ren), 1); chk("t5_addr2", 32'(rf_addr), 8);
    step(); step();                                      // T3
    chk("t5_vld2", 32'(op_valid), 1);
    chk("t5_rn2", op_rn, 108); chk("t5_rm2", op_rm, 0); chk("t5_rs2", op_rs, 0);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;

    // Back-to-back request offered while DONE
    offer(4'd1, 4'd0, 4'd0, 3'b001, 32'd0);
    step(); scramble();                                  // T1
    step(); step();                                      // T3
    chk("t6_vld_a", 32'(op_valid), 1); chk("t6_rn_a", op_rn, 101);
    op_ready = 1'b1;
    offer(4'd2, 4'd0, 4'd0, 3'b001, 32'd0);
`ifdef OPFETCH_B2B_EN
    chk("t6_b2b_ready", 32'(req_ready), 1);
    step(); scramble();
    chk("t6_b2b_fetch_ren", 32'(rf_ren), 1); chk("t6_b2b_fetch_addr", 32'(rf_addr), 2);
    chk("t6_b2b_vld_low", 32'(op_valid), 0); chk("t6_b2b_cleared", op_rn, 0);
    step(); step();
`else
    chk("t6_done_ready", 32'(req_ready), 0);
    step();
    chk("t6_idle_ready", 32'(req_ready), 1); chk("t6_idle_vld", 32'(op_valid), 0);
    chk("t6_idle_ren", 32'(rf_ren), 0);
    step(); scramble();
    chk("t6_fetch_ren", 32'(rf_ren), 1); chk("t6_fetch_addr", 32'(rf_addr), 2);
    step(); step();
`endif
    chk("t6_vld_b", 32'(op_valid), 1); chk("t6_rn_b", op_rn, 102);
    step();
    chk("t6_end_vld", 32'(op_valid), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
